// File: rtl/instr_encoder_loader.sv
// Encodes ALU requests into RV32 R-type words and streams them into instruction memory.
// Optional macro ENCODER_ITYPE_EN adds is_imm/imm inputs for I-type encoding.
module instr_encoder_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ALU_control,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
`ifdef ENCODER_ITYPE_EN
  input  logic              is_imm,
  input  logic [11:0]       imm,
`endif
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE, S_FULL} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  function automatic logic [2:0] funct3_of(input logic [3:0] op);
    case (op)
      4'b0000: return 3'b111;
      4'b0001: return 3'b110;
      4'b0010: return 3'b100;
      4'b0101: return 3'b001;
      4'b0110: return 3'b101;
      4'b0111: return 3'b101;
      4'b1000: return 3'b010;
      4'b1001: return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] funct7_of(input logic [3:0] op);
    return (op == 4'b0100 || op == 4'b0111) ? 7'b0100000 : 7'b0000000;
  endfunction

  function automatic logic legal_r(input logic [3:0] op);
    return op <= 4'd9;
  endfunction

`ifdef ENCODER_ITYPE_EN
  // Only ops with a direct immediate form in RV32I (no subi, shifts need shamt).
  function automatic logic legal_i(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1001: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
`endif

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [ADDR_W:0]   count_inc;
`ifdef ENCODER_ITYPE_EN
  logic              is_imm_q, is_imm_d;
  logic [11:0]       imm_q, imm_d;
`endif

  always_comb begin
    enc_word  = {funct7_of(op_q), rs2_q, rs1_q, funct3_of(op_q), rd_q, 7'b0110011};
    enc_legal = legal_r(op_q);
`ifdef ENCODER_ITYPE_EN
    if (is_imm_q) begin
      enc_word  = {imm_q, rs1_q, funct3_of(op_q), rd_q, 7'b0010011};
      enc_legal = legal_i(op_q);
    end
`endif
    count_inc   = count_q + 1'b1;
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;
    full_d      = full_q;
`ifdef ENCODER_ITYPE_EN
    is_imm_d    = is_imm_q;
    imm_d       = imm_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d    = ALU_control;
        rd_d    = rd;
        rs1_d   = rs1;
        rs2_d   = rs2;
`ifdef ENCODER_ITYPE_EN
        is_imm_d = is_imm;
        imm_d    = imm;
`endif
        state_d = S_ENC;
      end
      S_ENC: begin
        if (enc_legal) begin
          mem_wdata_d = enc_word;
          state_d     = S_WRITE;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        mem_we_d   = 1'b1;
        mem_addr_d = count_q[ADDR_W-1:0];
        count_d    = count_inc;
        full_d     = (count_inc == DEPTH_C);
        state_d    = (count_inc == DEPTH_C) ? S_FULL : S_IDLE;
      end
      default: ;
    endcase
    // clear overrides anything in flight: the pending request is dropped
    if (clear) begin
      state_d     = S_IDLE;
      count_d     = '0;
      full_d      = 1'b0;
      mem_we_d    = 1'b0;
      err_d       = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
`ifdef ENCODER_ITYPE_EN
      is_imm_q    <= 1'b0;
      imm_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      full_q      <= full_d;
`ifdef ENCODER_ITYPE_EN
      is_imm_q    <= is_imm_d;
      imm_q       <= imm_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized scoreboard bench for instr_encoder_loader (DEPTH=4 to exercise full/clear often).
module tb_instr_encoder_loader;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic clk = 0, rst_n = 0, in_valid = 0, clear = 0;
  logic [3:0] alu_op = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic is_imm = 0;
  logic [11:0] imm = 0;
  logic in_ready, mem_we, full, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [ADDR_W:0] count;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_control(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2),
`ifdef ENCODER_ITYPE_EN
    .is_imm(is_imm), .imm(imm),
`endif
    .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; logic [31:0] word; int at;} exp_t;
  exp_t sb[$];
  int   err_exp[$];
  int   n_cmp = 0, n_bad = 0;
  int   mcount = 0;

  // Reference tables indexed by ALU_control code.
  logic [2:0] F3 [16] = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b001, 3'b101, 3'b101,
                          3'b010, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
  bit IMM_OK [16] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

  function automatic logic [32:0] model(input logic [3:0] op, input logic [4:0] d, s1, s2,
                                        input logic ii, input logic [11:0] im);
    logic [6:0] f7;
    f7 = (op == 4'd4 || op == 4'd7) ? 7'h20 : 7'h00;
    if (ii) return {IMM_OK[op] == 1'b1, im, s1, F3[op], d, 7'h13};
    return {op < 4'd10, f7, s2, s1, F3[op], d, 7'h33};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes a write or an error.
  always @(negedge clk) if (rst_n) begin
    if (mem_we) begin
      if (sb.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", mem_wdata, e.word);
        chk("wr_latency", 32'(cyc), 32'(e.at));
        chk("wr_count", 32'(count), 32'(e.addr + 1));
        chk("wr_full", 32'(full), 32'(e.addr + 1 == DEPTH));
      end
    end
    if (err) begin
      if (err_exp.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
      else chk("err_latency", 32'(cyc), 32'(err_exp.pop_front()));
    end
  end

  task automatic send(input logic [3:0] op, input logic [4:0] d, s1, s2, input logic ii,
                      input logic [11:0] im, input logic have_exp, input logic [31:0] exp_w);
    logic [32:0] m;
    bit ok = 0;
    int k;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin chk("in_ready_timeout", 32'd0, 32'd1); return; end
    alu_op = op; rd = d; rs1 = s1; rs2 = s2; is_imm = ii; imm = im; in_valid = 1;
    @(posedge clk); #1;
    k = cyc;
    in_valid = 0;
    m = model(op, d, s1, s2, ii, im);
    if (have_exp) m[31:0] = exp_w;
    if (m[32]) begin
      sb.push_back('{addr: mcount, word: m[31:0], at: k + 2});
      mcount++;
    end else err_exp.push_back(k + 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 20; t++) begin
      if (sb.size() == 0 && err_exp.size() == 0) return;
      @(negedge clk); #1;
    end
    chk("drain_timeout", 32'(sb.size() + err_exp.size()), 32'd0);
  endtask

  task automatic full_then_clear();
    drain();
    @(negedge clk);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'(DEPTH));
    alu_op = 4'd3; is_imm = 0; in_valid = 1;
    repeat (3) @(negedge clk);
    in_valid = 0; clear = 1;
    @(negedge clk);
    clear = 0;
    mcount = 0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] op;
    logic ii;
    #2;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    send(4'd3, 5'd1, 5'd2, 5'd3, 1'b0, 12'd0, 1'b1, 32'h003100B3);
    send(4'd4, 5'd5, 5'd6, 5'd7, 1'b0, 12'd0, 1'b1, 32'h407302B3);
    send(4'hF, 5'd1, 5'd1, 5'd1, 1'b0, 12'd0, 1'b0, 32'd0);
    drain();
    chk("count_after_err", 32'(count), 32'd2);
`ifdef ENCODER_ITYPE_EN
    send(4'd3, 5'd1, 5'd0, 5'd0, 1'b1, 12'd5, 1'b1, 32'h00500093);
`else
    send(4'd0, 5'd0, 5'd31, 5'd17, 1'b0, 12'd0, 1'b0, 32'd0);
`endif
    send(4'd7, 5'd9, 5'd10, 5'd11, 1'b0, 12'd0, 1'b0, 32'd0);
    full_then_clear();

    // clear arriving together with an accept drops the request
    @(negedge clk);
    alu_op = 4'd3; in_valid = 1; clear = 1;
    @(negedge clk);
    in_valid = 0; clear = 0;
    repeat (4) @(negedge clk);
    chk("clr_accept_count", 32'(count), 32'd0);
    chk("clr_accept_ready", 32'(in_ready), 32'd1);

    // clear during WRITE wins: no strobe
    send(4'd1, 5'd2, 5'd3, 5'd4, 1'b0, 12'd0, 1'b0, 32'd0);
    @(negedge clk); @(negedge clk);
    clear = 1;
    void'(sb.pop_back());
    mcount = 0;
    @(negedge clk);
    clear = 0;
    repeat (3) @(negedge clk);
    chk("clr_write_count", 32'(count), 32'd0);

    // reset while the strobe is up
    send(4'd3, 5'd1, 5'd2, 5'd3, 1'b0, 12'd0, 1'b0, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_mem_we", 32'(mem_we), 32'd1);
    rst_n = 0;
    #1;
    chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    sb.delete();
    err_exp.delete();
    mcount = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 150; i++) begin
      if (mcount == DEPTH) full_then_clear();
      else if ($urandom_range(0, 19) == 0) begin
        drain();
        @(negedge clk); clear = 1;
        @(negedge clk); clear = 0;
        mcount = 0;
        chk("rand_clr_count", 32'(count), 32'd0);
      end else begin
        op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
`ifdef ENCODER_ITYPE_EN
        ii = 1'($urandom_range(0, 1));
`else
        ii = 1'b0;
`endif
        send(op, 5'($urandom), 5'($urandom), 5'($urandom), ii, 12'($urandom), 1'b0, 32'd0);
      end
    end
    drain();
    chk("final_count", 32'(count), 32'(mcount));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
